// File: rtl/ramb16_arb_pkg.sv
// Shared constants, FSM encoding and RAM address helper for the
// four-way RAMB16 port arbiter (512x36 aspect ratio).
package ramb16_arb_pkg;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 36;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // 36-bit aspect ratio: word index sits at bits [13:5].
  function automatic logic [14:0] ram_addr(
    input logic [ADDR_W-1:0] word
  );
    return {1'b0, word, 5'b0};
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker.
// Ports: req (requests), ptr (highest-priority index), gnt (one-hot).
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [7:0] dbl;
  logic [7:0] back;
  logic [3:0] rot;
  logic [3:0] pick;

  // Rotate so ptr lands at bit 0, take lowest set bit, rotate back.
  always_comb begin
    dbl  = {req, req} >> ptr;
    rot  = dbl[3:0];
    pick = rot & (~rot + 4'd1);
    back = {pick, pick} << ptr;
    gnt  = back[7:4];
  end

endmodule

// File: rtl/ramb16_port_arb.sv
// Shares one RAMB16 512x36 port among four requesters, clearing the array
// after reset. RAMB16_ARB_OUTREG_EN selects the RAM output register (L=2).
// Ports: CLK/RST, REQ/WE/ADDR/DI per requester, GNT/RVALID/DO/READY back,
// RAM_* drive one ramb16 port directly.
module ramb16_port_arb
  import ramb16_arb_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        WE,
  input  logic [NREQ*ADDR_W-1:0] ADDR,
  input  logic [NREQ*DATA_W-1:0] DI,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        RVALID,
  output logic [DATA_W-1:0]      DO,
  output logic                   READY,
  output logic                   RAM_EN,
  output logic                   RAM_SSR,
  output logic                   RAM_REGCE,
  output logic [3:0]             RAM_WE,
  output logic [14:0]            RAM_ADDR,
  output logic [31:0]            RAM_DI,
  output logic [3:0]             RAM_DIP,
  input  logic [31:0]            RAM_DO,
  input  logic [3:0]             RAM_DOP
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        ptr;
  logic [1:0]        idx;
  logic [NREQ-1:0]   arb_gnt;
  logic [NREQ-1:0]   rd_tag;
  logic [NREQ-1:0]   tag_out;
  logic [ADDR_W-1:0] word;
  logic [DATA_W-1:0] din;

  rr_arb4 u_arb (
    .req(REQ),
    .ptr(ptr),
    .gnt(arb_gnt)
  );

  assign GNT     = (state == RUN) ? arb_gnt : '0;
  assign READY   = (state == RUN);
  assign RAM_SSR = RST;
  assign DO      = {RAM_DOP, RAM_DO};
  assign rd_tag  = GNT & ~WE;

  always_comb begin
    idx = '0;
    unique case (1'b1)
      GNT[0]:  idx = 2'd0;
      GNT[1]:  idx = 2'd1;
      GNT[2]:  idx = 2'd2;
      GNT[3]:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign word = ADDR[int'(idx)*ADDR_W +: ADDR_W];
  assign din  = DI[int'(idx)*DATA_W +: DATA_W];

  always_comb begin
    state_n = state;
    if (state == CLEAR && cnt == ADDR_W'(DEPTH-1))
      state_n = RUN;
  end

  always_comb begin
    RAM_EN   = 1'b0;
    RAM_WE   = '0;
    RAM_ADDR = '0;
    RAM_DI   = '0;
    RAM_DIP  = '0;
    if (state == CLEAR) begin
      RAM_EN   = 1'b1;
      RAM_WE   = 4'hF;
      RAM_ADDR = ram_addr(cnt);
    end else if (|GNT) begin
      RAM_EN   = 1'b1;
      RAM_WE   = {4{WE[idx]}};
      RAM_ADDR = ram_addr(word);
      RAM_DI   = din[31:0];
      RAM_DIP  = din[35:32];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      if (state == CLEAR)
        cnt <= cnt + 1'b1;
      if (|GNT)
        ptr <= idx + 2'd1;
    end
  end

`ifdef RAMB16_ARB_OUTREG_EN
  logic [NREQ-1:0] tag1;
  logic [NREQ-1:0] tag2;

  assign RAM_REGCE = 1'b1;
  assign tag_out   = tag2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      tag1 <= rd_tag;
      tag2 <= tag1;
    end
  end
`else
  logic [NREQ-1:0] tag1;

  assign RAM_REGCE = 1'b0;
  assign tag_out   = tag1;

  always_ff @(posedge CLK) begin
    if (RST)
      tag1 <= '0;
    else
      tag1 <= rd_tag;
  end
`endif

  // A read issued just before reset must not surface while RST is high;
  // the flop flush only takes effect at the next edge.
  assign RVALID = RST ? '0 : tag_out;

endmodule

// File: tb/tb_ramb16_port_arb.sv
// Self-checking bench for ramb16_port_arb with a behavioural RAMB16 port.
// Build with or without RAMB16_ARB_OUTREG_EN.
module tb_ramb16_port_arb;

`ifdef RAMB16_ARB_OUTREG_EN
  localparam int   L         = 2;
  localparam logic EXP_REGCE = 1'b1;
`else
  localparam int   L         = 1;
  localparam logic EXP_REGCE = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   REQ;
  logic [3:0]   WE;
  logic [35:0]  ADDR;
  logic [143:0] DI;
  logic [3:0]   GNT;
  logic [3:0]   RVALID;
  logic [35:0]  DO;
  logic         READY;
  logic         RAM_EN;
  logic         RAM_SSR;
  logic         RAM_REGCE;
  logic [3:0]   RAM_WE;
  logic [14:0]  RAM_ADDR;
  logic [31:0]  RAM_DI;
  logic [3:0]   RAM_DIP;
  logic [31:0]  RAM_DO;
  logic [3:0]   RAM_DOP;

  always #5 CLK = ~CLK;

  ramb16_port_arb dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .DI(DI),
    .GNT(GNT), .RVALID(RVALID), .DO(DO), .READY(READY),
    .RAM_EN(RAM_EN), .RAM_SSR(RAM_SSR), .RAM_REGCE(RAM_REGCE),
    .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI),
    .RAM_DIP(RAM_DIP), .RAM_DO(RAM_DO), .RAM_DOP(RAM_DOP)
  );

  // RAMB16 port model, READ_FIRST, SRVAL 0.
  logic [35:0] mem [512];
  logic [35:0] lat;
  logic [35:0] oreg;
  logic        mem_init = 1'b0;
  wire  [8:0]  rw = RAM_ADDR[13:5];

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int k = 0; k < 512; k++) mem[k] = {4'($urandom), $urandom};
      mem_init = 1'b1;
    end
    if (RAM_EN) begin
      lat <= RAM_SSR ? 36'h0 : mem[rw];
      for (int k = 0; k < 4; k++)
        if (RAM_WE[k]) begin
          mem[rw][8*k +: 8] = RAM_DI[8*k +: 8];
          mem[rw][32+k]     = RAM_DIP[k];
        end
    end
    if (RAM_REGCE) oreg <= RAM_SSR ? 36'h0 : lat;
  end

  assign {RAM_DOP, RAM_DO} = (L == 2) ? oreg : lat;

  // Reference model state.
  bit [35:0] rmem [512];
  int        ptr_m;
  bit        ready_m;
  int        clr_m;
  int        edge_n;
  int        q_due[$];
  bit [3:0]  q_tag[$];
  bit [35:0] q_dat[$];
  logic [3:0] g_seen;
  int errors = 0;
  int checks = 0;

  function automatic bit [3:0] pick(bit [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (r[j]) return 4'(1 << j);
    end
    return 4'h0;
  endfunction

  task automatic chk(string tag, logic [35:0] obs, logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit [3:0] eg;
    bit [3:0] erv;
    bit [35:0] edo;
    int i;
    int a;
    #1;
    eg = ready_m ? pick(REQ, ptr_m) : 4'h0;
    g_seen = GNT;
    chk("gnt", GNT, eg);
    if (RST) chk("rvalid_in_rst", RVALID, 0);
    @(posedge CLK);
    edge_n++;
    if (RST) begin
      q_due.delete(); q_tag.delete(); q_dat.delete();
      ready_m = 0; clr_m = 0; ptr_m = 0;
    end else if (!ready_m) begin
      clr_m++;
      if (clr_m == 512) begin
        ready_m = 1;
        foreach (rmem[k]) rmem[k] = '0;
      end
    end else if (eg != 0) begin
      i = 0;
      for (int k = 0; k < 4; k++) if (eg[k]) i = k;
      a = int'(ADDR[9*i +: 9]);
      if (WE[i]) rmem[a] = DI[36*i +: 36];
      else begin
        q_due.push_back(edge_n + L - 1);
        q_tag.push_back(eg);
        q_dat.push_back(rmem[a]);
      end
      ptr_m = (i + 1) % 4;
    end
    #1;
    erv = 0; edo = 0;
    if (q_due.size() > 0 && q_due[0] == edge_n) begin
      void'(q_due.pop_front());
      erv = q_tag.pop_front();
      edo = q_dat.pop_front();
    end
    chk("rvalid", RVALID, erv);
    if (erv != 0) chk("do", DO, edo);
    chk("ready", READY, ready_m);
  endtask

  initial begin
    bit exp_rv1;
    RST = 1'b1; REQ = '0; WE = '0; ADDR = '0; DI = '0;
    @(posedge CLK);
    #1;
    ptr_m = 0; ready_m = 0; clr_m = 0; edge_n = 0;
    chk("rvalid_reset", RVALID, 0);
    chk("ready_reset", READY, 0);
    RST = 1'b0;
    #1;
    chk("gnt_reset", GNT, 0);
    chk("clr_addr0", RAM_ADDR, 15'h0);
    chk("clr_we", RAM_WE, 4'hF);
    chk("clr_en", RAM_EN, 1'b1);
    chk("clr_di", {RAM_DIP, RAM_DI}, 36'h0);
    chk("regce", RAM_REGCE, EXP_REGCE);

    // Clear sweep with a request pending the whole time.
    REQ = 4'h1;
    repeat (512) tick();
    REQ = '0;
    chk("clr_w0", mem[0], 36'h0);
    chk("clr_w255", mem[255], 36'h0);
    chk("clr_w511", mem[511], 36'h0);
    chk("ready_up", READY, 1'b1);

    // Fairness with all requests held.
    REQ = 4'hF; WE = 4'h0;
    ADDR = {9'h103, 9'h102, 9'h101, 9'h100};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_seq", g_seen, 36'(1 << (k % 4)));
    end
    REQ = '0;
    repeat (L) tick();

    // Single write then read by requester 2.
    REQ = 4'b0100; WE = 4'b0100;
    ADDR = '0; ADDR[26:18] = 9'h1A5;
    DI = '0; DI[107:72] = 36'hA_DEADBEEF;
    tick();
    WE = 4'b0000;
    tick();
    REQ = '0;
    repeat (L - 1) tick();
    chk("wr_rd_rv", RVALID, 4'b0100);
    chk("wr_rd_do", DO, 36'hA_DEADBEEF);
    repeat (2) tick();

    // Back-to-back reads by requester 1 alone.
    WE = '0;
    for (int t = 0; t < 4 + L; t++) begin
      if (t < 4) begin
        REQ = 4'b0010;
        ADDR = '0; ADDR[17:9] = 9'(t);
      end else REQ = '0;
      tick();
      if (t < 4) chk("b2b_gnt", g_seen, 4'b0010);
      exp_rv1 = (t >= L - 1) && (t < L + 3);
      chk("b2b_rv1", RVALID[1], exp_rv1);
    end
    repeat (2) tick();

    // Randomized traffic over a small address window.
    REQ = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (REQ[i] && g_seen[i]) REQ[i] = 1'b0;
        else if (REQ[i] && ($urandom % 16 == 0)) REQ[i] = 1'b0;
        if (!REQ[i] && ($urandom % 3 == 0)) begin
          REQ[i] = 1'b1;
          WE[i] = 1'($urandom);
          ADDR[9*i +: 9] = 9'($urandom % 16);
          DI[36*i +: 36] = {4'($urandom), $urandom};
        end
      end
      tick();
    end
    REQ = '0;
    repeat (L + 1) tick();

    // Read, then reset in the following cycle.
    REQ = 4'b0001; WE = 4'b0000; ADDR = '0; ADDR[8:0] = 9'd5;
    tick();
    REQ = '0;
    RST = 1'b1;
    #1;
    chk("ssr_rst", RAM_SSR, 1'b1);
    tick();
    RST = 1'b0;
    #1;
    chk("rst_ssr_low", RAM_SSR, 1'b0);
    chk("rst_addr0", RAM_ADDR, 15'h0);
    chk("rst_we", RAM_WE, 4'hF);
    REQ = 4'b1000;
    repeat (10) tick();
    chk("rst_addr10", RAM_ADDR, {1'b0, 9'd10, 5'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
